// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment controller: binary-to-BCD by iterative double-dabble,
// atomic digit commit, round-robin scan with a blanking interval per digit slot.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] bin_in,
  input  logic        bin_valid,
  output logic        bin_ready,
  input  logic        lzb_en,
  output logic        busy,
  output logic [6:0]  seg_out,
  output logic [3:0]  sel
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t         state_q, state_d;
  logic [13:0]    bin_q, bin_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [3:0]     it_q, it_d;
  logic [15:0]    disp_q, disp_d;
  logic [14:0]    adj;
  logic [PW-1:0]  pre_q, pre_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     sel_d;
  logic [6:0]     seg_d;
  logic [3:0]     digit;
  logic [3:0]     lead_zero;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  assign bin_ready = (state_q == IDLE);
  assign busy      = ~bin_ready;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    disp_d  = disp_q;
    // The thousands digit never reaches 5 before a shift because the input is
    // clamped to 9999, so only the lower three digits need the add-3 correction.
    adj     = bcd_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (bin_valid) begin
          bin_d   = (bin_in > 14'd9999) ? 14'd9999 : bin_in;
          bcd_d   = '0;
          it_d    = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj, bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        it_d  = it_q + 4'd1;
        if (it_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = (pre_q == PW'(CLK_DIV - 1)) ? '0 : pre_q + PW'(1);
    idx_d = (pre_q == PW'(CLK_DIV - 1)) ? idx_q + 2'd1 : idx_q;
    digit = disp_q[4*idx_d +: 4];
    lead_zero[3] = (disp_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    sel_d = 4'b1111;
    seg_d = 7'b0000000;
    if (32'(pre_d) >= BLANK_CYCLES) begin
      sel_d = ~(4'b0001 << idx_d);
      seg_d = (lzb_en && lead_zero[idx_d]) ? 7'b0000000 : seg_decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      sel     <= 4'b1111;
      seg_out <= 7'b0000000;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      sel     <= sel_d;
      seg_out <= seg_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues the expected per-slot
// {sel,seg}; a monitor pops and compares at the first lit cycle of every slot.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] bin_in = '0;
  logic        bin_valid = 1'b0;
  logic        bin_ready;
  logic        lzb_en = 1'b0;
  logic        busy;
  logic [6:0]  seg_out;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] prev_sel = 4'b1111;

  localparam logic [6:0] BL = 7'b0000000;
  logic [6:0] dec [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  display_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .lzb_en(lzb_en), .busy(busy), .seg_out(seg_out), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: busy must mirror bin_ready every cycle; each slot's first lit cycle is scored.
  always @(posedge clk) begin
    #1;
    chk("busy_inv", {15'd0, busy}, {15'd0, ~bin_ready});
    if (sel !== 4'b1111 && prev_sel === 4'b1111 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("slot_sel", {12'd0, sel}, {12'd0, mon_e.sel});
      chk("slot_seg", {9'd0, seg_out}, {9'd0, mon_e.seg});
    end
    prev_sel = sel;
  end

  task automatic push_slots(input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
    exp_q.push_back({4'b1110, d0});
    exp_q.push_back({4'b1101, d1});
    exp_q.push_back({4'b1011, d2});
    exp_q.push_back({4'b0111, d3});
  endtask

  task automatic send(input logic [13:0] v);
    @(negedge clk);
    bin_in    = v;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bin_ready && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in the blank interval immediately preceding a digit-0 slot.
  task automatic sync_slot0();
    int n = 0;
    while (sel !== 4'b0111 && n < 100) begin n++; @(posedge clk); #1; end
    while (sel !== 4'b1111 && n < 100) begin n++; @(posedge clk); #1; end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL sync_slot0: timeout waiting for slot boundary, sel=%b", sel);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin n++; @(posedge clk); end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d expected slots never observed", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Reset: outputs held at reset values for the whole reset window.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_sel", {12'd0, sel}, 16'h000f);
      chk("rst_seg", {9'd0, seg_out}, 16'h0000);
      chk("rst_ready", {15'd0, bin_ready}, 16'h0001);
    end
    rst = 1'b0;
    push_slots(dec[0], dec[0], dec[0], dec[0]);
    n = 0;
    while (sel === 4'b1111 && n < 20) begin n++; @(posedge clk); #1; end
    chk("first_lit_latency", 16'(n), 16'd2);
    drain("reset_display");

    // 1234: ready low for exactly 15 cycles, then digits 4,3,2,1 in index order.
    send(14'd1234);
    wait_ready(n);
    chk("ready_low_1234", 16'(n), 16'd15);
    sync_slot0();
    push_slots(dec[1], dec[2], dec[3], dec[4]);
    drain("show_1234");

    // Out-of-range value clamps to 9999.
    send(14'd12000);
    wait_ready(n);
    chk("ready_low_12000", 16'(n), 16'd15);
    sync_slot0();
    push_slots(dec[9], dec[9], dec[9], dec[9]);
    drain("show_clamp");

    // A new value offered mid-conversion is dropped.
    send(14'd1234);
    repeat (4) @(posedge clk);
    #1;
    bin_in    = 14'd4321;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    wait_ready(n);
    chk("ready_low_after_e5", 16'(n), 16'd10);
    sync_slot0();
    push_slots(dec[1], dec[2], dec[3], dec[4]);
    drain("ignore_4321");

    // Leading-zero blanking: only the units digit lights, sel still walks all slots.
    @(negedge clk);
    lzb_en = 1'b1;
    send(14'd7);
    wait_ready(n);
    sync_slot0();
    push_slots(BL, BL, BL, dec[7]);
    drain("lzb_7");

    // Interior zeros below the leading digit are not blanked.
    send(14'd1005);
    wait_ready(n);
    sync_slot0();
    push_slots(dec[1], dec[0], dec[0], dec[5]);
    drain("lzb_1005");

    // Reset at E7 abandons the conversion; display returns to 0 (single "0" with blanking).
    send(14'd5678);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sel", {12'd0, sel}, 16'h000f);
    chk("midrst_seg", {9'd0, seg_out}, 16'h0000);
    chk("midrst_ready", {15'd0, bin_ready}, 16'h0001);
    chk("midrst_busy", {15'd0, busy}, 16'h0000);
    rst = 1'b0;
    push_slots(BL, BL, BL, dec[0]);
    drain("midrst_display");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
